sin_rom_reader: RTL and testbench

SIN_ROM_READER -- requirements
Module: sin_rom_reader

---
 rtl/sin_rom_reader_if.sv | 25 ++
 rtl/sin_rom_reader.sv | 169 ++++++++++++++++
 tb/tb_sin_rom_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sin_rom_reader_if.sv
// Sine-ROM read bus. The reader drives address and control, and the ROM answers
// with data one clock after a cycle with ce high.
interface sin_rom_reader_if;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [7:0]  rom_dout;

    modport master (
        output rom_ad,
        output rom_ce,
        output rom_oce,
        output rom_reset,
        input  rom_dout
    );

    modport slave (
        input  rom_ad,
        input  rom_ce,
        input  rom_oce,
        input  rom_reset,
        output rom_dout
    );
endinterface

// File: rtl/sin_rom_reader.sv
// Sine-ROM player. While en is high it steps a wrapped address through the
// table at a programmable tick rate. It reads the ROM once per tick, scales each
// sample about the DAC mid-scale code, and presents the result two clocks after
// the read.
module sin_rom_reader #(
    parameter int unsigned TABLE_LEN = 1250,
    parameter logic [7:0]  MID       = 8'h80
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [10:0]             step,
    input  logic [10:0]             phase0,
    input  logic [15:0]             div,
    input  logic [8:0]              amp,
    sin_rom_reader_if.master        rom,
    output logic [7:0]              dac_data,
    output logic                    dac_valid,
    output logic                    wrap,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [11:0] TLEN = 12'(TABLE_LEN);

    state_t       state, state_nxt;
    logic [15:0]  div_q;
    logic [15:0]  tick_cnt;
    logic [10:0]  step_q;
    logic [10:0]  addr;
    logic         addr_wrapped;
    logic         tick;

    logic [11:0]  phase_ext;
    logic [11:0]  step_ext;
    logic [11:0]  addr_sum;
    logic [10:0]  start_addr;
    logic [10:0]  start_step;
    logic [10:0]  addr_next;
    logic         addr_next_wrap;

    logic         rd_vld;
    logic         rd_wrap;

    logic [8:0]          amp_eff;
    logic signed [17:0]  centered;
    logic signed [17:0]  product;
    logic signed [17:0]  scaled;
    logic [7:0]          sample;

    // A tick happens on RUN clocks where the divider has counted down to zero.
    assign tick = (state == RUN) && (tick_cnt == 16'd0);

    assign rom.rom_ad    = addr;
    assign rom.rom_ce    = tick;
    assign rom.rom_oce   = 1'b1;
    assign rom.rom_reset = reset;
    assign busy          = (state != IDLE);

    // Fold the start address and step into the table range, and form the next wrapped address.
    always_comb begin
        phase_ext      = {1'b0, phase0};
        step_ext       = {1'b0, step};
        start_addr     = (phase_ext >= TLEN) ? 11'(phase_ext - TLEN) : phase0;
        start_step     = (step_ext  >= TLEN) ? 11'(step_ext  - TLEN) : step;
        addr_sum       = {1'b0, addr} + {1'b0, step_q};
        addr_next_wrap = (addr_sum >= TLEN);
        addr_next      = addr_next_wrap ? 11'(addr_sum - TLEN) : addr_sum[10:0];
    end

    // Scale the ROM sample about MID by min(amp,256)/256, rounding toward -inf.
    always_comb begin
        amp_eff  = (amp > 9'd256) ? 9'd256 : amp;
        centered = $signed({10'd0, rom.rom_dout}) - $signed({10'd0, MID});
        product  = centered * $signed({9'd0, amp_eff});
        scaled   = (product >>> 8) + $signed({10'd0, MID});
        if (scaled < 0) begin
            sample = 8'h00;
        end else if (scaled > 18'sd255) begin
            sample = 8'hFF;
        end else begin
            sample = scaled[7:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DRAIN waits for the last read to come back and never restarts directly.
    always_comb begin
        // NOTE: the default is assigned before the case so that no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (en)      state_nxt = RUN;
            RUN:     if (!en)     state_nxt = DRAIN;
            DRAIN:   if (!rd_vld) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Address generator and tick divider. Loaded on start, cleared when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            step_q       <= '0;
            addr         <= '0;
            addr_wrapped <= 1'b0;
            tick_cnt     <= '0;
        end else if (state == IDLE) begin
            if (en) begin
                div_q        <= div;
                step_q       <= start_step;
                addr         <= start_addr;
                addr_wrapped <= 1'b0;
                tick_cnt     <= '0;
            end else begin
                addr         <= '0;
                addr_wrapped <= 1'b0;
                tick_cnt     <= '0;
            end
        end else if (state == RUN) begin
            if (tick) begin
                tick_cnt     <= div_q;
                addr         <= addr_next;
                addr_wrapped <= addr_next_wrap;
            end else begin
                tick_cnt     <= tick_cnt - 16'd1;
            end
        end else if (state_nxt == IDLE) begin
            addr         <= '0;
            addr_wrapped <= 1'b0;
            tick_cnt     <= '0;
        end
    end

    // Two-stage read pipeline: the ROM answers in the next clock, and the DAC output is registered one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld    <= 1'b0;
            rd_wrap   <= 1'b0;
            dac_valid <= 1'b0;
            wrap      <= 1'b0;
            dac_data  <= MID;
        end else begin
            rd_vld    <= tick;
            rd_wrap   <= tick & addr_wrapped;
            dac_valid <= rd_vld;
            wrap      <= rd_vld & rd_wrap;
            if (rd_vld) begin
                dac_data <= sample;
            end else if (state_nxt == IDLE) begin
                dac_data <= MID;
            end
        end
    end

endmodule

// File: tb/tb_sin_rom_reader.sv
// Self-checking bench for sin_rom_reader. A ROM model returns rom_ad[7:0]
// one clock after ce. Expected addresses, samples, wrap flags and busy
// windows are computed arithmetically from the start parameters.
module tb_sin_rom_reader;

    localparam int TLEN  = 1250;
    localparam int MID_I = 128;

    logic        clk;
    logic        reset;
    logic        en;
    logic [10:0] step;
    logic [10:0] phase0;
    logic [15:0] div;
    logic [8:0]  amp;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        wrap;
    logic        busy;

    sin_rom_reader_if rom_bus ();

    sin_rom_reader #(
        .TABLE_LEN (TLEN),
        .MID       (8'h80)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .step      (step),
        .phase0    (phase0),
        .div       (div),
        .amp       (amp),
        .rom       (rom_bus),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: synchronous read of the low address byte.
    always @(posedge clk) begin
        if (rom_bus.rom_ce) rom_bus.rom_dout <= rom_bus.rom_ad[7:0];
    end

    int checks = 0;
    int errors = 0;
    int m_a0;
    int m_sl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int scale_ref(input int rom_val, input int a_in);
        int a, d, p, q, r;
        a = (a_in > 256) ? 256 : a_in;
        d = rom_val - MID_I;
        p = d * a;
        if (p >= 0) q = p / 256;
        else        q = -((-p + 255) / 256);
        r = MID_I + q;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int addr_ref(input int k);
        return (m_a0 + k * m_sl) % TLEN;
    endfunction

    function automatic bit wrap_ref(input int k);
        if (k == 0) return 1'b0;
        return (addr_ref(k - 1) + m_sl) >= TLEN;
    endfunction

    // One complete run: start, run for n_run RUN clocks with the inputs disturbed,
    // then either drop en and drain, or pulse reset with reads in flight.
    task automatic run_case(input int p0, input int st, input int dv, input int am,
                            input int n_run, input bit rst_mode);
        int per, l_run, last_tick, busy_end, last_idx, k, exp_data;
        bit exp_ce, exp_valid, exp_wrap, exp_busy;
        m_a0      = p0 % TLEN;
        m_sl      = st % TLEN;
        per       = dv + 1;
        l_run     = n_run - 1;
        last_tick = (l_run / per) * per;
        busy_end  = (l_run + 1 > last_tick + 2) ? l_run + 1 : last_tick + 2;
        last_idx  = rst_mode ? l_run + 5 : busy_end + 3;
        exp_data  = MID_I;
        @(negedge clk);
        phase0 = 11'(p0);
        step   = 11'(st);
        div    = 16'(dv);
        amp    = 9'(am);
        en     = 1'b1;
        for (int idx = 0; idx <= last_idx; idx++) begin
            @(negedge clk);
            exp_ce    = (idx <= l_run) && (idx % per == 0);
            exp_valid = (idx >= 2) && (idx - 2 <= l_run) && ((idx - 2) % per == 0)
                        && (!rst_mode || idx <= l_run);
            exp_wrap  = 1'b0;
            if (exp_valid) begin
                k        = (idx - 2) / per;
                exp_data = scale_ref(addr_ref(k) % 256, am);
                exp_wrap = wrap_ref(k);
            end
            exp_busy = rst_mode ? (idx <= l_run) : (idx <= busy_end);
            if (!exp_busy) exp_data = MID_I;
            check("rom_ce",    32'(rom_bus.rom_ce), 32'(exp_ce));
            check("dac_valid", 32'(dac_valid),      32'(exp_valid));
            check("wrap",      32'(wrap),           32'(exp_wrap));
            check("busy",      32'(busy),           32'(exp_busy));
            check("dac_data",  32'(dac_data),       32'(exp_data));
            check("rom_oce",   32'(rom_bus.rom_oce), 32'd1);
            check("rom_reset", 32'(rom_bus.rom_reset), 32'(reset));
            if (exp_ce) begin
                check("rom_ad", 32'(rom_bus.rom_ad), 32'(addr_ref(idx / per)));
            end else if (rst_mode && idx > l_run) begin
                check("rom_ad_rst", 32'(rom_bus.rom_ad), 32'd0);
            end
            if (idx < l_run) begin
                step   = 11'($urandom);
                phase0 = 11'($urandom);
                div    = 16'($urandom_range(0, 9));
            end else if (idx == l_run) begin
                en = 1'b0;
                if (rst_mode) reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        step   = '0;
        phase0 = '0;
        div    = '0;
        amp    = 9'd256;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),              32'd0);
        check("rst_dac_valid", 32'(dac_valid),         32'd0);
        check("rst_wrap",      32'(wrap),              32'd0);
        check("rst_dac_data",  32'(dac_data),          32'h80);
        check("rst_rom_ce",    32'(rom_bus.rom_ce),    32'd0);
        check("rst_rom_ad",    32'(rom_bus.rom_ad),    32'd0);
        check("rst_rom_oce",   32'(rom_bus.rom_oce),   32'd1);
        check("rst_rom_reset", 32'(rom_bus.rom_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rom_reset_low", 32'(rom_bus.rom_reset), 32'd0);

        // Full table sweep at unity gain: wrap from 1249 back to 0.
        run_case(0, 1, 0, 256, 1260, 1'b0);
        // Out-of-range start and step folded into the table, one tick every four clocks.
        run_case(1300, 1400, 3, 256, 40, 1'b0);
        // Zero amplitude, half amplitude on zero-valued samples, over-unity clamp.
        run_case(17, 33, 0, 0, 20, 1'b0);
        run_case(0, 256, 1, 128, 9, 1'b0);
        run_case(5, 77, 2, 300, 30, 1'b0);
        // Zero step holds the address.
        run_case(600, 0, 1, 200, 12, 1'b0);
        // en dropped just after a tick with div=0.
        run_case(10, 3, 0, 256, 7, 1'b0);
        // Drain with the last tick one clock before en falls.
        run_case(900, 500, 1, 256, 8, 1'b0);
        // Reset with reads in flight, then restart from the same phase.
        run_case(321, 45, 0, 256, 15, 1'b1);
        run_case(321, 45, 0, 256, 10, 1'b0);
        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            run_case(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 511)),
                     int'($urandom_range(5, 60)), 1'b0);
        end
        run_case(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                 0, int'($urandom_range(0, 511)), 12, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
